// File: rtl/axi4s_uart_pkg.sv
// rtl/axi4s_uart_pkg.sv - shared types, constants and round-robin search for the UART TX arbiter
package axi4s_uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Returns {valid, index}: first set bit of req searching from last+1 with wrap modulo n.
    function automatic logic [3:0] next_grant(input logic [MAX_SRC-1:0] req, input int n, input int last);
        logic [3:0] res;
        logic [2:0] idx3;
        int         idx;
        res = 4'd0;
        // Walk the rotation backwards so the nearest candidate is the one left standing.
        for (int k = MAX_SRC; k >= 1; k--) begin
            if (k <= n) begin
                idx  = (last + k) % n;
                idx3 = idx[2:0];
                if (req[idx3]) begin
                    res = {1'b1, idx3};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4s_uart_rr_arbiter.sv
// rtl/axi4s_uart_rr_arbiter.sv - combinational round-robin pick from a request vector and the last grant
module axi4s_uart_rr_arbiter
    import axi4s_uart_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [MAX_SRC-1:0] req_ext;
    logic [3:0]         res;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_SRC-1:0] = req;
        res                  = next_grant(req_ext, NUM_SRC, int'(last));
        gnt_valid            = res[3];
        gnt_idx              = IDX_W'(res[2:0]);
    end

endmodule

// File: rtl/axi4s_uart_tx_arbiter.sv
// rtl/axi4s_uart_tx_arbiter.sv - packet round-robin arbiter onto one UART byte stream; AXI4S_UART_ARB_ID_EN adds an ID prefix byte
module axi4s_uart_tx_arbiter
    import axi4s_uart_pkg::*;
#(
    parameter int         NUM_SRC     = 2,
    parameter logic [7:0] SRC_ID_BASE = 8'hF0,
    localparam int        IDX_W       = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    output logic [NUM_SRC-1:0]        s_tready,
    input  logic [NUM_SRC*BYTE_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic                      tx_byte_tvalid,
    input  logic                      tx_byte_tready,
    output logic [BYTE_W-1:0]         tx_byte_tdata,
    output logic                      tx_byte_tkeep,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              slot_free;
    logic              beat_acc;
    logic              cur_valid;
    logic              cur_last;
    logic [BYTE_W-1:0] cur_data;

    axi4s_uart_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (s_tvalid),
        .last      (grant_idx),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign tx_byte_tkeep = 1'b1;
    assign slot_free     = !tx_byte_tvalid || tx_byte_tready;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                cur_valid = s_tvalid[i];
                cur_last  = s_tlast[i];
                cur_data  = s_tdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign beat_acc = (state == DATA) && cur_valid && slot_free;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
`ifdef AXI4S_UART_ARB_ID_EN
                    state_nxt = HDR;
`else
                    state_nxt = DATA;
`endif
                end
            end
            HDR: begin
                if (slot_free) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (beat_acc && cur_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset so no source beat is consumed on the edge that discards the slot.
    always_comb begin
        busy     = (state != IDLE);
        s_tready = '0;
        if (state == DATA && aresetn) begin
            s_tready[grant_idx] = slot_free;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tx_byte_tvalid <= 1'b0;
            tx_byte_tdata  <= '0;
            grant_idx      <= IDX_W'(NUM_SRC - 1);
        end else begin
            if (state == IDLE && arb_valid) begin
                grant_idx <= arb_idx;
            end
            if (slot_free) begin
                if (state == HDR) begin
                    tx_byte_tvalid <= 1'b1;
                    tx_byte_tdata  <= SRC_ID_BASE + 8'(grant_idx);
                end else if (beat_acc) begin
                    tx_byte_tvalid <= 1'b1;
                    tx_byte_tdata  <= cur_data;
                end else begin
                    tx_byte_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4s_uart_tx_arbiter.sv
// tb/tb_axi4s_uart_tx_arbiter.sv - self-checking bench for axi4s_uart_tx_arbiter with three sources
module tb_axi4s_uart_tx_arbiter;

    localparam int N = 3;
    localparam logic [7:0] ID_BASE = 8'hF0;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [N-1:0] s_tvalid;
    logic [N-1:0] s_tready;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0] s_tlast;
    logic         tx_byte_tvalid;
    logic         tx_byte_tready;
    logic [7:0]   tx_byte_tdata;
    logic         tx_byte_tkeep;
    logic [1:0]   grant_idx;
    logic         busy;

    axi4s_uart_tx_arbiter #(
        .NUM_SRC     (N),
        .SRC_ID_BASE (ID_BASE)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tlast        (s_tlast),
        .tx_byte_tvalid (tx_byte_tvalid),
        .tx_byte_tready (tx_byte_tready),
        .tx_byte_tdata  (tx_byte_tdata),
        .tx_byte_tkeep  (tx_byte_tkeep),
        .grant_idx      (grant_idx),
        .busy           (busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [23:0] data;
        logic [2:0]  last;
        logic        exp_tvalid;
        logic [7:0]  exp_tdata;
        logic [2:0]  exp_srdy;
        logic        exp_busy;
        logic [1:0]  exp_gidx;
    } vec_t;

    logic [8:0] srcq [N][$];
    logic [7:0] outq [$];
    logic [7:0] expq [$];
    int         out_time [$];
    int         start_at [N];
    int         cyc;
    int         stall_lo;
    int         stall_hi;

    logic [N-1:0] hs_src;
    logic         hs_out;
    logic [7:0]   out_d;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_d = 8'h00;

    // Handshakes are sampled mid-cycle; a stalled slot must hold its byte and keep every source idle.
    always @(negedge aclk) begin
        hs_src     <= s_tvalid & s_tready;
        hs_out     <= tx_byte_tvalid && tx_byte_tready;
        out_d      <= tx_byte_tdata;
        if (aresetn) begin
            if (prev_stall) begin
                chk("stall_hold_data", 32'(tx_byte_tdata), 32'(prev_d));
                chk("stall_hold_valid", 32'(tx_byte_tvalid), 32'd1);
            end
            if (tx_byte_tvalid && !tx_byte_tready) begin
                chk("stall_s_tready", 32'(s_tready), 32'd0);
            end
        end
        prev_stall <= aresetn && tx_byte_tvalid && !tx_byte_tready;
        prev_d     <= tx_byte_tdata;
    end

    task automatic drive_inputs();
        logic [8:0]  h;
        logic [23:0] d;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && cyc >= start_at[i]) begin
                h = srcq[i][0];
                s_tvalid[i] = 1'b1;
                s_tlast[i]  = h[8];
                d = d | (24'(h[7:0]) << (8 * i));
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        s_tdata = d;
        tx_byte_tready = !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    task automatic model_cycle();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_src[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
            end
        end
        if (hs_out) begin
            outq.push_back(out_d);
            out_time.push_back(cyc);
        end
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        tx_byte_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            start_at[i] = 0;
        end
        outq.delete();
        expq.delete();
        out_time.delete();
        stall_lo = 0;
        stall_hi = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc = 0;
    endtask

    task automatic src_pkt(input int src, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            srcq[src].push_back({k == len - 1, 8'(base + k)});
        end
    endtask

    task automatic exp_pkt(input int src, input int base, input int len);
`ifdef AXI4S_UART_ARB_ID_EN
        expq.push_back(8'(ID_BASE + 8'(src)));
`endif
        for (int k = 0; k < len; k++) begin
            expq.push_back(8'(base + k));
        end
    endtask

    // Runs until the expected byte count leaves the arbiter, then idles to catch duplicates.
    task automatic run_and_check(input string name, input int budget);
        int b;
        b = 0;
        while (outq.size() < expq.size() && b < budget) begin
            model_cycle();
            b++;
        end
        if (outq.size() < expq.size()) begin
            chk({name, "_timeout"}, 32'(outq.size()), 32'(expq.size()));
        end
        repeat (6) model_cycle();
        chk({name, "_count"}, 32'(outq.size()), 32'(expq.size()));
        for (int k = 0; k < expq.size() && k < outq.size(); k++) begin
            chk($sformatf("%s_byte%0d", name, k), 32'(outq[k]), 32'(expq[k]));
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{3'b010, 24'h004100, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 2'd2};
        tbl[1] = '{3'b010, 24'h004100, 3'b000, 1'b0, 8'h00, 3'b010, 1'b1, 2'd1};
        tbl[2] = '{3'b010, 24'h004200, 3'b000, 1'b1, 8'h41, 3'b010, 1'b1, 2'd1};
        tbl[3] = '{3'b010, 24'h004300, 3'b010, 1'b1, 8'h42, 3'b010, 1'b1, 2'd1};
        tbl[4] = '{3'b000, 24'h000000, 3'b000, 1'b1, 8'h43, 3'b000, 1'b0, 2'd1};
        tbl[5] = '{3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 2'd1};

        do_reset();
        chk("rst_tvalid", 32'(tx_byte_tvalid), 32'd0);
        chk("rst_tdata", 32'(tx_byte_tdata), 32'd0);
        chk("rst_tkeep", 32'(tx_byte_tkeep), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gidx", 32'(grant_idx), 32'd2);
        chk("rst_s_tready", 32'(s_tready), 32'd0);

`ifndef AXI4S_UART_ARB_ID_EN
        for (int r = 0; r < 6; r++) begin
            s_tvalid = tbl[r].valid;
            s_tdata  = tbl[r].data;
            s_tlast  = tbl[r].last;
            tx_byte_tready = 1'b1;
            #1;
            chk($sformatf("vec%0d_tvalid", r), 32'(tx_byte_tvalid), 32'(tbl[r].exp_tvalid));
            if (tbl[r].exp_tvalid) begin
                chk($sformatf("vec%0d_tdata", r), 32'(tx_byte_tdata), 32'(tbl[r].exp_tdata));
            end
            chk($sformatf("vec%0d_s_tready", r), 32'(s_tready), 32'(tbl[r].exp_srdy));
            chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
            chk($sformatf("vec%0d_gidx", r), 32'(grant_idx), 32'(tbl[r].exp_gidx));
            @(posedge aclk);
            #1;
        end
`endif

        // Every source requests continuously: strict rotation starting at source 0.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < N; s++) begin
                src_pkt(s, s * 16, 2);
                exp_pkt(s, s * 16, 2);
            end
        end
        drive_inputs();
        run_and_check("rotation", 200);
`ifndef AXI4S_UART_ARB_ID_EN
        for (int k = 1; k < out_time.size(); k++) begin
            chk($sformatf("rotation_gap%0d", k), 32'(out_time[k] - out_time[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);
        end
`endif

        // A late request from source 2 must not split the source 0 packet.
        do_reset();
        src_pkt(0, 'hA0, 4);
        src_pkt(2, 'hC0, 2);
        start_at[2] = 2;
        exp_pkt(0, 'hA0, 4);
        exp_pkt(2, 'hC0, 2);
        drive_inputs();
        run_and_check("no_preempt", 200);

        // Transmitter stalls five cycles mid-packet.
        do_reset();
        src_pkt(1, 'h60, 5);
        exp_pkt(1, 'h60, 5);
        stall_lo = 4;
        stall_hi = 9;
        drive_inputs();
        run_and_check("backpressure", 200);

        // One-cycle reset after the second byte of a five-byte packet.
        do_reset();
        src_pkt(0, 'h50, 5);
        drive_inputs();
        for (int b = 0; b < 100 && outq.size() < 2; b++) begin
            model_cycle();
        end
        chk("rst_mid_reached", 32'(outq.size() >= 2), 32'd1);
        aresetn = 1'b0;
        model_cycle();
        aresetn = 1'b1;
        chk("rst_mid_tvalid", 32'(tx_byte_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_gidx", 32'(grant_idx), 32'd2);
        outq.delete();
        out_time.delete();
        expq.delete();
`ifdef AXI4S_UART_ARB_ID_EN
        expq.push_back(ID_BASE);
`endif
        for (int k = 0; k < srcq[0].size(); k++) begin
            expq.push_back(srcq[0][k][7:0]);
        end
        chk("rst_mid_remainder", 32'(srcq[0].size() > 0), 32'd1);
        run_and_check("rst_mid", 200);

        // Single-beat packet from source 2.
        do_reset();
        src_pkt(2, 'h55, 1);
        exp_pkt(2, 'h55, 1);
        drive_inputs();
        run_and_check("single", 100);
        chk("single_gidx", 32'(grant_idx), 32'd2);
        chk("single_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
